// File: rtl/instr_exec_unit_if.sv
// Bus between the execution unit, the instruction register it reads and the
// consumer of its results.
//
// Result handshake: res_valid/res_data/res_addr/res_err are driven by the
// master and stay stable from the cycle res_valid rises until the first
// rising edge where res_valid && res_ready. The master never drops res_valid
// without that transfer. res_ready may be high at any time; it means nothing
// while res_valid is low.
interface instr_exec_unit_if #(
    parameter int OP_WIDTH   = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0]   read_pointer;
    logic [4+2*OP_WIDTH-1:0] instruction_word;
    logic                    res_valid;
    logic                    res_ready;
    logic [2*OP_WIDTH-1:0]   res_data;
    logic [ADDR_WIDTH-1:0]   res_addr;
    logic                    res_err;

    modport master (
        output read_pointer,
        input  instruction_word,
        output res_valid,
        input  res_ready,
        output res_data,
        output res_addr,
        output res_err
    );

    modport slave (
        input  read_pointer,
        output instruction_word,
        input  res_valid,
        output res_ready,
        input  res_data,
        input  res_addr,
        input  res_err
    );
endinterface

// File: rtl/instr_exec_unit.sv
// Execution stage behind the instruction register. A start command sweeps
// read_pointer from first_addr to last_addr (wrapping through the top of the
// address space), executes each captured {opc, op_a, op_b} and offers one
// result per instruction on the res_* handshake. DIV/MOD run on an iterative
// restoring divider (OP_WIDTH cycles); every other opcode takes one cycle.
//
// Optional build macro EXEC_PERF_CNT_EN adds saturating exec_count and
// err_count outputs counting result handshakes and error handshakes.
//
// dbg_state exposes the FSM state (IDLE=0, FETCH=1, EXEC=2, DIVIDE=3,
// OUTPUT=4) for observation.
module instr_exec_unit #(
    parameter int OP_WIDTH   = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    instr_exec_unit_if.master     rbus,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            dbg_state
`ifdef EXEC_PERF_CNT_EN
    ,
    output logic [15:0]           exec_count,
    output logic [15:0]           err_count
`endif
);

    localparam int RW = 2 * OP_WIDTH;
    localparam int CW = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;

    localparam logic [3:0] OPC_ZERO  = 4'd0;
    localparam logic [3:0] OPC_PASSA = 4'd1;
    localparam logic [3:0] OPC_PASSB = 4'd2;
    localparam logic [3:0] OPC_ADD   = 4'd3;
    localparam logic [3:0] OPC_SUB   = 4'd4;
    localparam logic [3:0] OPC_MULT  = 4'd5;
    localparam logic [3:0] OPC_DIV   = 4'd6;
    localparam logic [3:0] OPC_MOD   = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_DIVIDE = 3'd3,
        S_OUTPUT = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic [3:0]            opc_q, opc_d;
    logic [OP_WIDTH-1:0]   op_a_q, op_a_d;
    logic [OP_WIDTH-1:0]   op_b_q, op_b_d;
    logic                  res_valid_q, res_valid_d;
    logic [RW-1:0]         res_data_q, res_data_d;
    logic [ADDR_WIDTH-1:0] res_addr_q, res_addr_d;
    logic                  res_err_q, res_err_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Divider: remainder, dividend/quotient shift register, divisor magnitude
    logic [OP_WIDTH-1:0]   div_rem_q, div_rem_d;
    logic [OP_WIDTH-1:0]   div_quo_q, div_quo_d;
    logic [OP_WIDTH-1:0]   div_dvsr_q, div_dvsr_d;
    logic [CW-1:0]         div_cnt_q, div_cnt_d;
    logic                  div_qneg_q, div_qneg_d;
    logic                  div_rneg_q, div_rneg_d;
    logic                  div_mod_q, div_mod_d;

`ifdef EXEC_PERF_CNT_EN
    logic [15:0]           exec_cnt_q, exec_cnt_d;
    logic [15:0]           err_cnt_q, err_cnt_d;
`endif

    // Operand views: sign-extended to result width and unsigned magnitudes.
    // Widening before add/sub/mul keeps every carry and the full product.
    logic [RW-1:0]       a_ext, b_ext, sum_ext, diff_ext, prod_ext;
    logic [OP_WIDTH-1:0] a_mag, b_mag;

    // Operand widening and plain-arithmetic results for single-cycle opcodes
    always_comb begin
        a_ext    = {{OP_WIDTH{op_a_q[OP_WIDTH-1]}}, op_a_q};
        b_ext    = {{OP_WIDTH{op_b_q[OP_WIDTH-1]}}, op_b_q};
        sum_ext  = a_ext + b_ext;
        diff_ext = a_ext - b_ext;
        prod_ext = a_ext * b_ext;
        a_mag    = op_a_q[OP_WIDTH-1] ? (~op_a_q + 1'b1) : op_a_q;
        b_mag    = op_b_q[OP_WIDTH-1] ? (~op_b_q + 1'b1) : op_b_q;
    end

    // One restoring divider step plus the sign-corrected final result
    logic [OP_WIDTH:0]   div_partial, div_trial;
    logic                div_ge;
    logic [OP_WIDTH-1:0] div_rem_nx, div_quo_nx;
    logic [RW-1:0]       div_mag, div_res;

    always_comb begin
        div_partial = {div_rem_q, div_quo_q[OP_WIDTH-1]};
        div_trial   = div_partial - {1'b0, div_dvsr_q};
        div_ge      = ~div_trial[OP_WIDTH];
        div_rem_nx  = div_ge ? div_trial[OP_WIDTH-1:0] : div_partial[OP_WIDTH-1:0];
        div_quo_nx  = {div_quo_q[OP_WIDTH-2:0], div_ge};
        div_mag     = div_mod_q ? {{OP_WIDTH{1'b0}}, div_rem_nx}
                                : {{OP_WIDTH{1'b0}}, div_quo_nx};
        if (div_mod_q ? div_rneg_q : div_qneg_q) begin
            div_res = ~div_mag + 1'b1;
        end else begin
            div_res = div_mag;
        end
    end

    // Next-state and next-output computation for the whole unit
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        last_d      = last_q;
        opc_d       = opc_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_addr_d  = res_addr_q;
        res_err_d   = res_err_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        div_rem_d   = div_rem_q;
        div_quo_d   = div_quo_q;
        div_dvsr_d  = div_dvsr_q;
        div_cnt_d   = div_cnt_q;
        div_qneg_d  = div_qneg_q;
        div_rneg_d  = div_rneg_q;
        div_mod_d   = div_mod_q;
`ifdef EXEC_PERF_CNT_EN
        exec_cnt_d  = exec_cnt_q;
        err_cnt_d   = err_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                // The cycle carrying the done pulse never accepts a start
                if (start && !done_q) begin
                    last_d   = last_addr;
                    rd_ptr_d = first_addr;
                    busy_d   = 1'b1;
                    state_d  = S_FETCH;
`ifdef EXEC_PERF_CNT_EN
                    exec_cnt_d = 16'd0;
                    err_cnt_d  = 16'd0;
`endif
                end
            end

            S_FETCH: begin
                opc_d   = rbus.instruction_word[4+RW-1 -: 4];
                op_a_d  = rbus.instruction_word[RW-1 -: OP_WIDTH];
                op_b_d  = rbus.instruction_word[OP_WIDTH-1:0];
                state_d = S_EXEC;
            end

            S_EXEC: begin
                res_addr_d  = rd_ptr_q;
                res_err_d   = 1'b0;
                res_data_d  = '0;
                res_valid_d = 1'b1;
                state_d     = S_OUTPUT;
                case (opc_q)
                    OPC_ZERO:  res_data_d = '0;
                    OPC_PASSA: res_data_d = a_ext;
                    OPC_PASSB: res_data_d = b_ext;
                    OPC_ADD:   res_data_d = sum_ext;
                    OPC_SUB:   res_data_d = diff_ext;
                    OPC_MULT:  res_data_d = prod_ext;
                    OPC_DIV, OPC_MOD: begin
                        if (op_b_q == '0) begin
                            res_err_d = 1'b1;
                        end else begin
                            res_valid_d = 1'b0;
                            state_d     = S_DIVIDE;
                            div_rem_d   = '0;
                            div_quo_d   = a_mag;
                            div_dvsr_d  = b_mag;
                            div_cnt_d   = '0;
                            div_qneg_d  = op_a_q[OP_WIDTH-1] ^ op_b_q[OP_WIDTH-1];
                            div_rneg_d  = op_a_q[OP_WIDTH-1];
                            div_mod_d   = (opc_q == OPC_MOD);
                        end
                    end
                    default:   res_err_d = 1'b1;
                endcase
            end

            S_DIVIDE: begin
                div_rem_d = div_rem_nx;
                div_quo_d = div_quo_nx;
                div_cnt_d = div_cnt_q + CW'(1);
                if (div_cnt_q == CW'(OP_WIDTH - 1)) begin
                    res_data_d  = div_res;
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = S_OUTPUT;
                end
            end

            S_OUTPUT: begin
                if (rbus.res_ready) begin
                    res_valid_d = 1'b0;
`ifdef EXEC_PERF_CNT_EN
                    if (exec_cnt_q != 16'hFFFF) exec_cnt_d = exec_cnt_q + 16'd1;
                    if (res_err_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
`endif
                    if (res_addr_q == last_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
                        state_d  = S_FETCH;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any run without a done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            last_q      <= '0;
            opc_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_addr_q  <= '0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_rem_q   <= '0;
            div_quo_q   <= '0;
            div_dvsr_q  <= '0;
            div_cnt_q   <= '0;
            div_qneg_q  <= 1'b0;
            div_rneg_q  <= 1'b0;
            div_mod_q   <= 1'b0;
`ifdef EXEC_PERF_CNT_EN
            exec_cnt_q  <= 16'd0;
            err_cnt_q   <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            last_q      <= last_d;
            opc_q       <= opc_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_addr_q  <= res_addr_d;
            res_err_q   <= res_err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_rem_q   <= div_rem_d;
            div_quo_q   <= div_quo_d;
            div_dvsr_q  <= div_dvsr_d;
            div_cnt_q   <= div_cnt_d;
            div_qneg_q  <= div_qneg_d;
            div_rneg_q  <= div_rneg_d;
            div_mod_q   <= div_mod_d;
`ifdef EXEC_PERF_CNT_EN
            exec_cnt_q  <= exec_cnt_d;
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    assign rbus.read_pointer = rd_ptr_q;
    assign rbus.res_valid    = res_valid_q;
    assign rbus.res_data     = res_data_q;
    assign rbus.res_addr     = res_addr_q;
    assign rbus.res_err      = res_err_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign dbg_state         = state_q;
`ifdef EXEC_PERF_CNT_EN
    assign exec_count        = exec_cnt_q;
    assign err_count         = err_cnt_q;
`endif

endmodule

// File: tb/tb_instr_exec_unit.sv
// Bench for instr_exec_unit: directed runs from the test plan followed by
// randomized register contents, each result compared against an arithmetic
// reference model (64-bit integer math on the specified opcode rules).
module tb_instr_exec_unit;
    localparam int W  = 32;
    localparam int AW = 5;
    localparam int NLOC = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] first_addr, last_addr;
    logic          busy, done;
    logic [2:0]    dbg_state;
`ifdef EXEC_PERF_CNT_EN
    logic [15:0]   exec_count, err_count;
`endif

    instr_exec_unit_if #(.OP_WIDTH(W), .ADDR_WIDTH(AW)) bus ();

    logic [4+2*W-1:0] mem [NLOC];
    assign bus.instruction_word = mem[bus.read_pointer];

    instr_exec_unit #(.OP_WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rbus       (bus),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
`ifdef EXEC_PERF_CNT_EN
        ,
        .exec_count (exec_count),
        .err_count  (err_count)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;

    // Count done pulses as seen at each active edge
    always @(posedge clk) if (done) done_seen++;

    // Watchdog so the run always ends
    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard queues
    logic [2*W-1:0] exp_q[$];
    logic           exp_err_q[$];
    logic [AW-1:0]  exp_addr_q[$];
    int             exp_lat_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_loc(input int addr, input logic [3:0] opc, input logic [W-1:0] a, input logic [W-1:0] b);
        mem[addr] = {opc, a, b};
    endtask

    // Reference model straight from the opcode rules, using 64-bit integers
    function automatic void ref_exec(input logic [3:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [2*W-1:0] d, output logic e);
        longint la, lb;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        d = '0;
        e = 1'b0;
        case (opc)
            4'd0: d = '0;
            4'd1: d = la;
            4'd2: d = lb;
            4'd3: d = la + lb;
            4'd4: d = la - lb;
            4'd5: d = la * lb;
            4'd6: if (lb == 0) e = 1'b1; else d = la / lb;
            4'd7: if (lb == 0) e = 1'b1; else d = la % lb;
            default: e = 1'b1;
        endcase
    endfunction

    // One complete run: start, collect every result, check done behaviour.
    // stall < 0 : res_ready held high throughout; otherwise ready is low for
    // 'stall' cycles after each res_valid before the handshake.
    task automatic run_sweep(input int first, input int last, input int stall);
        int n, waited, errs;
        logic [2*W-1:0] d, ed;
        logic e, ee;
        logic [AW-1:0] ea;
        int el;
        n = ((last - first + NLOC) % NLOC) + 1;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            int addr;
            logic [3:0] opc;
            addr = (first + i) % NLOC;
            opc  = mem[addr][4+2*W-1 -: 4];
            ref_exec(opc, mem[addr][2*W-1 -: W], mem[addr][W-1:0], d, e);
            exp_q.push_back(d);
            exp_err_q.push_back(e);
            exp_addr_q.push_back(AW'(addr));
            exp_lat_q.push_back(((opc == 4'd6 || opc == 4'd7) && !e) ? (W + 2) : 2);
            if (e) errs++;
        end

        start = 1'b1;
        first_addr = AW'(first);
        last_addr  = AW'(last);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("rp_first", bus.read_pointer, first);
`ifdef EXEC_PERF_CNT_EN
        check("exec_count_clear", exec_count, 0);
        check("err_count_clear", err_count, 0);
`endif
        bus.res_ready = (stall < 0);

        for (int i = 0; i < n; i++) begin
            waited = 0;
            while (!bus.res_valid && waited < 100) begin
                @(posedge clk); #1;
                waited++;
            end
            ed = exp_q.pop_front();
            ee = exp_err_q.pop_front();
            ea = exp_addr_q.pop_front();
            el = exp_lat_q.pop_front();
            check("res_valid", bus.res_valid, 1'b1);
            check("latency", waited, el);
            check("res_data", bus.res_data, ed);
            check("res_err", bus.res_err, ee);
            check("res_addr", bus.res_addr, ea);
            if (stall >= 0) begin
                for (int s = 0; s < stall; s++) begin
                    @(posedge clk); #1;
                    check("stall_valid", bus.res_valid, 1'b1);
                    check("stall_data", bus.res_data, ed);
                    check("stall_addr", bus.res_addr, ea);
                    check("stall_err", bus.res_err, ee);
                end
                bus.res_ready = 1'b1;
            end
            @(posedge clk); #1;
            if (stall >= 0) bus.res_ready = 1'b0;
            check("valid_drop", bus.res_valid, 1'b0);
            if (i == n - 1) begin
                check("done_pulse", done, 1'b1);
                check("busy_end", busy, 1'b0);
`ifdef EXEC_PERF_CNT_EN
                check("exec_count", exec_count, n);
                check("err_count", err_count, errs);
`endif
                // start during the done cycle must be ignored
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                check("start_on_done_ignored", busy, 1'b0);
                check("done_single_cycle", done, 1'b0);
            end else begin
                check("done_mid_run", done, 1'b0);
                check("rp_next", bus.read_pointer, (ea + 1) % NLOC);
            end
        end
        bus.res_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 4))
            0: rand_op = W'($urandom_range(0, 20)) - W'(10);
            1: rand_op = '0;
            2: rand_op = 32'h8000_0000;
            default: rand_op = $urandom;
        endcase
    endfunction

    initial begin
        int d0;
        // Clock/reset
        reset = 1'b1;
        start = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < NLOC; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rp", bus.read_pointer, 0);
        check("rst_valid", bus.res_valid, 0);
        check("rst_data", bus.res_data, 0);
        check("rst_addr", bus.res_addr, 0);
        check("rst_err", bus.res_err, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // ADD / SUB / PASSB with ready held high
        set_loc(0, 4'd3, 32'd5, -32'sd7);
        set_loc(1, 4'd4, -32'sd15, 32'd15);
        set_loc(2, 4'd2, 32'd0, 32'd9);
        d0 = done_seen;
        run_sweep(0, 2, -1);
        check("one_done_run1", done_seen - d0, 1);

        // MULT full-width product
        set_loc(5, 4'd5, -32'sd65536, 32'd65536);
        run_sweep(5, 5, 0);

        // Division cases, undefined opcode, MOD overflow corner
        set_loc(6, 4'd6, -32'sd7, 32'd2);
        set_loc(7, 4'd7, -32'sd7, 32'd2);
        set_loc(8, 4'd6, 32'd7, 32'd0);
        set_loc(9, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        set_loc(10, 4'd12, 32'd3, 32'd4);
        set_loc(11, 4'd7, 32'h8000_0000, 32'hFFFF_FFFF);
        run_sweep(6, 11, 1);

        // Wrapping sweep with long stalls
        set_loc(30, 4'd1, 32'd30, 32'd0);
        set_loc(31, 4'd3, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        set_loc(0, 4'd4, 32'h8000_0000, 32'd1);
        set_loc(1, 4'd7, 32'd100, -32'sd7);
        run_sweep(30, 1, 5);

        // Reset in the middle of a divide
        set_loc(4, 4'd6, 32'd1000, 32'd7);
        start = 1'b1;
        first_addr = 5'd4;
        last_addr  = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        d0 = done_seen;
        reset = 1'b1;
        #1;
        check("abort_rp", bus.read_pointer, 0);
        check("abort_valid", bus.res_valid, 0);
        check("abort_data", bus.res_data, 0);
        check("abort_addr", bus.res_addr, 0);
        check("abort_err", bus.res_err, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_seen - d0, 0);
        check("abort_idle_busy", busy, 0);
        run_sweep(4, 4, 0);

        // Mixed run with two error results
        set_loc(12, 4'd3, 32'd1, 32'd2);
        set_loc(13, 4'd12, 32'd1, 32'd2);
        set_loc(14, 4'd6, 32'd9, 32'd0);
        set_loc(15, 4'd7, 32'd9, 32'd4);
        run_sweep(12, 15, 0);
        run_sweep(13, 13, 0);

        // Randomized register contents, ranges and stalls
        for (int r = 0; r < 4; r++) begin
            int f, l, st;
            for (int i = 0; i < NLOC; i++) begin
                logic [3:0] opc;
                opc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
                set_loc(i, opc, rand_op(), rand_op());
            end
            f  = $urandom_range(0, NLOC - 1);
            l  = $urandom_range(0, NLOC - 1);
            st = int'($urandom_range(0, 3)) - 1;
            run_sweep(f, l, st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_exec_unit.md
Name: instr_exec_unit

Overview:
- Execution stage directly downstream of the instruction register.
- On a start command, sweeps the register's read_pointer from first_addr to last_addr and captures each instruction_word {opc, op_a, op_b}.
- Executes each instruction and presents one result per instruction on a valid/ready output port.
- DIV/MOD use an iterative multi-cycle divider; all other opcodes complete in one cycle.

Parameters:
- OP_WIDTH, 32, width of signed operands op_a and op_b.
- ADDR_WIDTH, 5, width of register addresses; matches address_t.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; ignored while busy=1.
- first_addr  input  ADDR_WIDTH  first register location to execute; sampled when start is accepted.
- last_addr  input  ADDR_WIDTH  last register location to execute; sampled when start is accepted.
- read_pointer  output  ADDR_WIDTH  address to the instruction register; registered.
- instruction_word  input  4+2*OP_WIDTH  combinational read data {opc[3:0], op_a, op_b}.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  2*OP_WIDTH  signed result.
- res_addr  output  ADDR_WIDTH  register location that produced res_data.
- res_err  output  1  divide-by-zero or undefined opcode.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse at end of run.

Behaviour:
- Reset values: read_pointer=0, res_valid=0, res_data=0, res_addr=0, res_err=0, busy=0, done=0, FSM=IDLE, divider cleared. Reset aborts any run immediately; no done pulse is produced.
- States: IDLE, FETCH, EXEC, DIVIDE, OUTPUT.
- IDLE: start=1 latches first_addr/last_addr, sets read_pointer=first_addr and busy=1 → FETCH.
- FETCH: instruction_word is captured at the end of this cycle → EXEC.
- EXEC, single-cycle opcodes: result is computed and registered, res_valid=1 next cycle → OUTPUT.
- EXEC, DIV/MOD: divider is loaded → DIVIDE. If op_b=0, go straight to OUTPUT with res_err=1.
- DIVIDE: restoring unsigned divide on operand magnitudes, one quotient bit per cycle, OP_WIDTH cycles, sign correction applied on exit → OUTPUT.
- OUTPUT: res_valid, res_data, res_addr and res_err are held stable until res_valid && res_ready.
  - On handshake, if res_addr==last_addr: busy=0, done=1 for one cycle → IDLE.
  - Otherwise read_pointer+1, wrapping 2^ADDR_WIDTH-1 → 0 → FETCH.
- Latency, FETCH in cycle t: single-cycle ops give res_valid at t+2. DIV/MOD with op_b≠0 give res_valid at t+2+OP_WIDTH. Divide-by-zero gives res_valid at t+2.
- Arithmetic: all results are sign-extended to 2*OP_WIDTH.
  - 0 ZERO → 0.
  - 1 PASSA → op_a.
  - 2 PASSB → op_b.
  - 3 ADD → op_a+op_b at OP_WIDTH+1 bits, then sign-extended; no overflow loss.
  - 4 SUB → op_a-op_b, same widening rule as ADD.
  - 5 MULT → full signed 2*OP_WIDTH product.
  - 6 DIV → quotient truncated toward zero.
  - 7 MOD → remainder carrying the sign of op_a.
  - 8-15 → res_data=0, res_err=1.
- Divide by zero: res_data=0, res_err=1.
- Special case: op_a=-2^(OP_WIDTH-1), op_b=-1 with DIV → +2^(OP_WIDTH-1), i.e. 0x0000_0000_8000_0000 for OP_WIDTH=32.
- Address range:
  - first_addr==last_addr: exactly one instruction executes.
  - first_addr>last_addr: the sweep wraps through 2^ADDR_WIDTH-1 to 0, giving 2^ADDR_WIDTH-first_addr+last_addr+1 results.
- Output port rules: res_valid is never dropped without a handshake; res_ready=1 while res_valid=0 has no effect.
- start asserted in the same cycle as done: ignored. A new run can only start from IDLE on the following cycle.

Optional Feature:
- Macro: EXEC_PERF_CNT_EN.
- Defined: adds output ports exec_count[15:0] and err_count[15:0].
  - Both counters clear when start is accepted.
  - exec_count increments on each result handshake.
  - err_count increments on each handshake with res_err=1.
  - Both saturate at 16'hFFFF.
  - Both reset to 0.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Run with first=0, last=2. Loc0 ADD a=5 b=-7, loc1 SUB a=-15 b=15, loc2 PASSB b=9, res_ready=1 → results -2, -30, 9 with res_addr 0, 1, 2; one done pulse; busy low after.
- MULT a=-65536 b=65536 → res_data=0xFFFF_FFFF_0000_0000 (-2^32), res_valid at t+2.
- DIV a=-7 b=2 → -3 at t+34. MOD a=-7 b=2 → -1. DIV a=7 b=0 → res_data=0, res_err=1 at t+2. DIV a=0x8000_0000 b=-1 → 0x0000_0000_8000_0000.
- Run with first=30, last=1, res_ready held low 5 cycles per result → res_addr sequence 30, 31, 0, 1; outputs stable while stalled; read_pointer wraps 31 → 0.
- Assert reset during DIVIDE on loc 4 → all outputs at reset values immediately, no done. A following start with first=4, last=4 completes normally.
- EXEC_PERF_CNT_EN defined, 4 instructions including opc=12 and one DIV by 0 → exec_count=4, err_count=2. Second start → both clear to 0.
